// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory with programmable wait states,
// byte/half/word accesses with sign/zero extension and misalignment flagging,
// a per-word dirty bitmap for the debug unit, and debug reads that are only
// served while the pipeline has released the memory (enable_i=0, FSM idle).
//
// Handshake: req_i is sampled only in IDLE with enable_i=1 (that edge is the
// accept). busy_o stays high from the cycle after accept until the done_o
// cycle inclusive; done_o (and err_o for a misaligned access) is a one-cycle
// pulse, and rdata_o is valid in that cycle and held until the next done_o.
module mem_access_unit #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    input  logic [NB_ADDR-1:0] addr_i,
    input  logic [NB_DATA-1:0] wdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [NB_DATA-1:0] rdata_o,
    input  logic               dbg_rd_i,
    input  logic [NB_ADDR-3:0] dbg_addr_i,
    input  logic               dbg_clr_i,
    output logic [NB_DATA-1:0] dbg_data_o,
    output logic               dbg_dirty_o,
    output logic [NB_ADDR-2:0] dirty_cnt_o,
    output logic [1:0]         dbg_state_o
);

    localparam int NB_IDX   = NB_ADDR - 2;
    localparam int DEPTH    = 1 << NB_IDX;
    localparam int NB_BYTES = NB_DATA / 8;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [NB_DATA-1:0] rdata_q, rdata_d;
    logic [NB_DATA-1:0] dbg_data_q, dbg_data_d;
    logic [DEPTH-1:0]   dirty_q, dirty_d;
    logic [NB_ADDR-2:0] dirty_cnt_q, dirty_cnt_d;

    logic [NB_DATA-1:0] mem_q [DEPTH];

    // Access attributes: live inputs in IDLE (zero-wait commits on the accept
    // edge itself), latched copies once the access is in flight.
    logic               idle;
    logic               accept;
    logic               a_we;
    logic [1:0]         a_size;
    logic               a_uns;
    logic [NB_ADDR-1:0] a_addr;
    logic [NB_DATA-1:0] a_wdata;
    logic [NB_IDX-1:0]  a_idx;
    logic               misaligned;
    logic               commit;
    logic               commit_wr;
    logic               commit_rd;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] load_ext;
    logic [NB_BYTES-1:0] wr_be;
    logic [NB_DATA-1:0] wr_word;
    logic               dbg_take;

    assign idle      = (state_q == S_IDLE);
    assign accept    = idle && req_i && enable_i;
    assign a_we      = idle ? we_i       : we_q;
    assign a_size    = idle ? size_i     : size_q;
    assign a_uns     = idle ? unsigned_i : uns_q;
    assign a_addr    = idle ? addr_i     : addr_q;
    assign a_wdata   = idle ? wdata_i    : wdata_q;
    assign a_idx     = a_addr[NB_ADDR-1:2];

    assign misaligned = ((a_size == 2'b01) && a_addr[0]) ||
                        (a_size[1] && (a_addr[1:0] != 2'b00));

    // Commit happens on the edge that leaves the last wait cycle, or on the
    // accept edge when there are no wait states.
    assign commit    = (accept && !misaligned && ZERO_WAIT) ||
                       ((state_q == S_WAIT) && (cnt_q <= 4'd1));
    assign commit_wr = commit && a_we;
    assign commit_rd = commit && !a_we;

    assign rd_word   = mem_q[a_idx];
    assign rd_byte   = rd_word[{a_addr[1:0], 3'b000} +: 8];
    assign rd_half   = rd_word[{a_addr[1], 4'b0000} +: 16];
    assign dbg_take  = dbg_rd_i && !enable_i && idle;

    // Lane extraction and sign/zero extension of load data
    always_comb begin
        load_ext = rd_word;
        case (a_size)
            2'b00:   load_ext = a_uns ? {{(NB_DATA-8){1'b0}}, rd_byte}
                                      : {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = a_uns ? {{(NB_DATA-16){1'b0}}, rd_half}
                                      : {{(NB_DATA-16){rd_half[15]}}, rd_half};
            default: load_ext = rd_word;
        endcase
    end

    // Byte-lane enables and replicated store data for the addressed lanes
    always_comb begin
        wr_be   = '1;
        wr_word = a_wdata;
        case (a_size)
            2'b00: begin
                wr_be   = NB_BYTES'(1) << a_addr[1:0];
                wr_word = {NB_BYTES{a_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = NB_BYTES'(3) << {a_addr[1], 1'b0};
                wr_word = {(NB_DATA/16){a_wdata[15:0]}};
            end
            default: begin
                wr_be   = '1;
                wr_word = a_wdata;
            end
        endcase
    end

    // FSM, request latching, load data and debug read next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = unsigned_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    err_d   = misaligned;
                    if (misaligned || ZERO_WAIT) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = WS_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                err_d   = 1'b0;
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
        rdata_d    = commit_rd ? load_ext : rdata_q;
        dbg_data_d = dbg_take ? mem_q[dbg_addr_i] : dbg_data_q;
    end

    // Dirty bitmap and population count; a commit's set wins over a clear
    always_comb begin
        dirty_d     = dbg_clr_i ? '0 : dirty_q;
        dirty_cnt_d = dirty_cnt_q;
        if (commit_wr) begin
            dirty_d[a_idx] = 1'b1;
        end
        if (dbg_clr_i) begin
            dirty_cnt_d = commit_wr ? (NB_ADDR-1)'(1) : '0;
        end else if (commit_wr && !dirty_q[a_idx]) begin
            dirty_cnt_d = dirty_cnt_q + (NB_ADDR-1)'(1);
        end
    end

    // Control and output registers, cleared by the asynchronous reset
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            dbg_data_q  <= '0;
            dirty_q     <= '0;
            dirty_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            dbg_data_q  <= dbg_data_d;
            dirty_q     <= dirty_d;
            dirty_cnt_q <= dirty_cnt_d;
        end
    end

    // Memory array write port (contents survive reset)
    always_ff @(posedge clock_i) begin
        if (commit_wr) begin
            for (int b = 0; b < NB_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[a_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    assign busy_o      = !idle;
    assign done_o      = (state_q == S_DONE);
    assign err_o       = done_o && err_q;
    assign rdata_o     = rdata_q;
    assign dbg_data_o  = dbg_data_q;
    assign dbg_dirty_o = dirty_q[dbg_addr_i];
    assign dirty_cnt_o = dirty_cnt_q;
    assign dbg_state_o = state_q;

endmodule
